// File: rtl/axi_rom_responder_if.sv
// AXI read-address and read-data channels between the bridge (master) and the ROM responder (slave).
interface axi_rom_responder_if #(
  parameter int IDS_W  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) ();
  logic [IDS_W-1:0]  ARID_S;
  logic [ADDR_W-1:0] ARADDR;
  logic [LEN_W-1:0]  ARLEN;
  logic [1:0]        ARBURST;
  logic              ARVALID;
  logic              ARREADY;
  logic [IDS_W-1:0]  RID_S;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;

  modport master (
    output ARID_S, ARADDR, ARLEN, ARBURST, ARVALID,
    input  ARREADY,
    input  RID_S, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

  modport slave (
    input  ARID_S, ARADDR, ARLEN, ARBURST, ARVALID,
    output ARREADY,
    output RID_S, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );
endinterface

// File: rtl/axi_rom_responder.sv
// AXI read slave for the boot ROM: one burst at a time, first beat 3 cycles after AR, then 1 beat/cycle.
// RREADY backpressure is absorbed by a 2-entry buffer; ROM issue pauses when buffer + in-flight read reach 2.
module axi_rom_responder #(
  parameter int IDS_W  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4,
  parameter int ROM_AW = 12
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  axi_rom_responder_if.slave axi,
  output logic              ROM_CS,
  output logic              ROM_OE,
  output logic [ROM_AW-1:0] ROM_A,
  input  logic [DATA_W-1:0] ROM_DO
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state, state_nxt;
  logic [IDS_W-1:0]   id_q;
  logic [ROM_AW-1:0]  addr_q, addr_nxt, mask_q;
  logic [1:0]         burst_q;
  logic [LEN_W:0]     issue_left;
  logic               inflight, inflight_last;
  logic [DATA_W-1:0]  fifo_dat [2];
  logic [1:0]         fifo_last;
  logic               rd_ptr, wr_ptr;
  logic [1:0]         fifo_cnt;
  logic [2:0]         occ;
  logic               ar_hs, issue, pop, fifo_vld, head_last, wrap_ok;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^{axi.ARADDR[ADDR_W-1:ROM_AW+2], axi.ARADDR[1:0]};

  assign fifo_vld  = (fifo_cnt != 2'd0);
  assign head_last = fifo_last[rd_ptr];
  assign ar_hs     = axi.ARVALID && (state == IDLE);
  assign pop       = fifo_vld && axi.RREADY;
  // Occupancy as it will stand after this cycle's pop; RREADY reaches ROM_CS combinationally.
  assign occ       = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = (state == BURST) && (issue_left != '0) && (occ < 3'd2);

  // Wrapping only applies to power-of-two lengths of 2..16 beats; anything else increments.
  assign wrap_ok = (mask_q != '0) && ((mask_q & (mask_q + 1'b1)) == '0);

  always_comb begin
    addr_nxt = addr_q + 1'b1;
    case (burst_q)
      2'b00:   addr_nxt = addr_q;
      2'b10:   if (wrap_ok) addr_nxt = (addr_q & ~mask_q) | ((addr_q + 1'b1) & mask_q);
      default: addr_nxt = addr_q + 1'b1;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ar_hs) state_nxt = BURST;
      BURST:   if (pop && head_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    axi.ARREADY = (state == IDLE);
    ROM_CS      = issue;
    ROM_OE      = issue;
    ROM_A       = addr_q;
    axi.RVALID  = fifo_vld;
    axi.RDATA   = fifo_dat[rd_ptr];
    axi.RLAST   = fifo_vld && head_last;
    axi.RID_S   = id_q;
    axi.RRESP   = (burst_q == 2'b11) ? 2'b10 : 2'b00;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      id_q          <= '0;
      addr_q        <= '0;
      mask_q        <= '0;
      burst_q       <= 2'b00;
      issue_left    <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      if (ar_hs) begin
        id_q       <= axi.ARID_S;
        addr_q     <= axi.ARADDR[ROM_AW+1:2];
        mask_q     <= ROM_AW'(axi.ARLEN);
        burst_q    <= axi.ARBURST;
        issue_left <= {1'b0, axi.ARLEN} + 1'b1;
      end else if (issue) begin
        addr_q     <= addr_nxt;
        issue_left <= issue_left - 1'b1;
      end
      inflight      <= issue;
      inflight_last <= issue && (issue_left == (LEN_W+1)'(1));
    end
  end

  // ROM data lands one cycle after the issue and goes straight into the buffer.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      fifo_dat[0] <= '0;
      fifo_dat[1] <= '0;
      fifo_last   <= 2'b00;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      if (inflight) begin
        fifo_dat[wr_ptr]  <= ROM_DO;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_axi_rom_responder.sv
// Randomized scoreboard bench for axi_rom_responder with a behavioural ROM and burst address model.
module tb_axi_rom_responder;

  typedef struct {
    logic [31:0] dat;
    logic        last;
    logic [7:0]  id;
    logic [1:0]  resp;
  } beat_t;

  logic        ACLK, ARESETn;
  logic        ROM_CS, ROM_OE;
  logic [11:0] ROM_A;
  logic [31:0] ROM_DO;
  logic [31:0] rom [4096];

  axi_rom_responder_if #(.IDS_W(8), .ADDR_W(32), .DATA_W(32), .LEN_W(4)) axi ();

  axi_rom_responder #(.IDS_W(8), .ADDR_W(32), .DATA_W(32), .LEN_W(4), .ROM_AW(12)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .axi(axi),
    .ROM_CS(ROM_CS), .ROM_OE(ROM_OE), .ROM_A(ROM_A), .ROM_DO(ROM_DO)
  );

  int total = 0, bad = 0;
  int cyc = 0, t_ar = 0, lo_start = -100;
  int first_cs_cyc, first_rv_cyc, last_cyc, pops, outstanding;
  bit armed_cs, armed_rv, rr_rand;
  beat_t       exp_q[$];
  logic [11:0] exp_a[$];

  initial begin
    ACLK = 0;
    forever #5 ACLK = ~ACLK;
  end

  always @(posedge ACLK) cyc <= cyc + 1;

  always @(posedge ACLK) if (ROM_CS) ROM_DO <= rom[ROM_A];

  always @(posedge ACLK) begin
    #2;
    if (cyc >= lo_start && cyc < lo_start + 5) axi.RREADY = 1'b0;
    else if (rr_rand) axi.RREADY = 1'($urandom_range(0, 1));
    else axi.RREADY = 1'b1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every issued ROM address and every presented beat is checked against the queues.
  always @(negedge ACLK) begin
    if (ARESETn) begin
      if (ROM_CS) begin
        if (armed_cs) begin first_cs_cyc = cyc; armed_cs = 0; end
        outstanding++;
        if (exp_a.size() == 0) chk("rom_a_extra_issue", 1, 0);
        else chk("rom_a", ROM_A, exp_a.pop_front());
      end
      if (axi.RVALID) begin
        if (armed_rv) begin first_rv_cyc = cyc; armed_rv = 0; end
        if (exp_q.size() == 0) chk("rvalid_unexpected", 1, 0);
        else begin
          chk("rdata", axi.RDATA, exp_q[0].dat);
          chk("rlast", axi.RLAST, exp_q[0].last);
          chk("rid", axi.RID_S, exp_q[0].id);
          chk("rresp", axi.RRESP, exp_q[0].resp);
          if (axi.RREADY) begin
            if (exp_q[0].last) last_cyc = cyc;
            void'(exp_q.pop_front());
            pops++;
            outstanding--;
          end
        end
      end
      if (outstanding > 2) chk("outstanding_le_2", outstanding, 2);
    end
  end

  function automatic logic [11:0] next_w(input logic [11:0] w, input int len, input logic [1:0] bt);
    int sz, base;
    if (bt == 2'b00) return w;
    if (bt == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      sz   = len + 1;
      base = int'(w) - (int'(w) % sz);
      return 12'(base + ((int'(w) + 1 - base) % sz));
    end
    return 12'((int'(w) + 1) % 4096);
  endfunction

  task automatic ar_start(input logic [7:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] bt, input bit stall);
    logic [11:0] w;
    beat_t b;
    w = addr[13:2];
    for (int i = 0; i <= len; i++) begin
      exp_a.push_back(w);
      b.dat = rom[w]; b.last = (i == len); b.id = id; b.resp = (bt == 2'b11) ? 2'b10 : 2'b00;
      exp_q.push_back(b);
      w = next_w(w, len, bt);
    end
    @(posedge ACLK); #1;
    chk("arready_idle", axi.ARREADY, 1);
    axi.ARID_S = id; axi.ARADDR = addr; axi.ARLEN = 4'(len); axi.ARBURST = bt; axi.ARVALID = 1'b1;
    t_ar = cyc; armed_cs = 1; armed_rv = 1; pops = 0;
    if (stall) lo_start = cyc + 3;
    @(posedge ACLK); #1;
    axi.ARVALID = 1'b0;
    chk("arready_busy", axi.ARREADY, 0);
  endtask

  task automatic wait_done(input bit tchk, input int len);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_a.size() != 0) && n < 300) begin
      @(posedge ACLK); #1;
      n++;
    end
    if (n >= 300) begin
      chk("burst_timeout", exp_q.size(), 0);
      exp_q.delete(); exp_a.delete();
    end
    if (tchk) begin
      chk("first_issue_cycle", first_cs_cyc, t_ar + 1);
      chk("first_rvalid_cycle", first_rv_cyc, t_ar + 3);
      chk("rlast_cycle", last_cyc, t_ar + len + 3);
      chk("idle_cycle", cyc, t_ar + len + 4);
      chk("arready_after", axi.ARREADY, 1);
    end
  endtask

  task automatic burst(input logic [7:0] id, input logic [31:0] addr, input int len,
                       input logic [1:0] bt, input bit tchk, input bit stall);
    ar_start(id, addr, len, bt, stall);
    wait_done(tchk, len);
  endtask

  initial begin
    int n, len;
    logic [1:0] bt;
    ARESETn = 0;
    axi.ARVALID = 0; axi.ARID_S = 0; axi.ARADDR = 0; axi.ARLEN = 0; axi.ARBURST = 0;
    axi.RREADY = 1; rr_rand = 0; outstanding = 0; pops = 0;
    armed_cs = 0; armed_rv = 0; first_cs_cyc = -1; first_rv_cyc = -1; last_cyc = -1;
    for (int i = 0; i < 4096; i++) rom[i] = $urandom;
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_rvalid", axi.RVALID, 0);
    chk("rst_rlast", axi.RLAST, 0);
    chk("rst_rdata", axi.RDATA, 0);
    chk("rst_rid", axi.RID_S, 0);
    chk("rst_rresp", axi.RRESP, 0);
    chk("rst_rom_cs", ROM_CS, 0);
    chk("rst_rom_oe", ROM_OE, 0);
    chk("rst_rom_a", ROM_A, 0);
    chk("rst_arready", axi.ARREADY, 1);
    @(posedge ACLK); #1;
    ARESETn = 1;

    burst(8'h25, 32'h10, 0, 2'b01, 1, 0);
    burst(8'h31, 32'h20, 3, 2'b01, 1, 0);
    burst(8'h32, 32'h3FFC, 1, 2'b01, 1, 0);
    burst(8'h40, 32'h100, 7, 2'b01, 0, 1);
    burst(8'h41, 32'h38, 3, 2'b10, 1, 0);
    burst(8'h42, 32'h40, 2, 2'b00, 1, 0);
    burst(8'h43, 32'h80, 1, 2'b11, 1, 0);

    // Reset in the middle of a burst: remaining beats are dropped.
    ar_start(8'h5A, 32'h200, 7, 2'b01, 0);
    n = 0;
    while (pops < 2 && n < 50) begin
      @(posedge ACLK); #1;
      n++;
    end
    chk("two_beats_before_reset", pops >= 2, 1);
    ARESETn = 0;
    #1;
    chk("reset_rvalid", axi.RVALID, 0);
    chk("reset_arready", axi.ARREADY, 1);
    chk("reset_rom_cs", ROM_CS, 0);
    exp_q.delete(); exp_a.delete();
    outstanding = 0; armed_cs = 0; armed_rv = 0;
    repeat (2) @(posedge ACLK);
    #1;
    ARESETn = 1;
    burst(8'h11, 32'h0, 0, 2'b01, 1, 0);

    for (int i = 0; i < 40; i++) begin
      bt = 2'($urandom_range(0, 3));
      if (bt == 2'b10) begin
        case ($urandom_range(0, 3))
          0: len = 1;
          1: len = 3;
          2: len = 7;
          default: len = 15;
        endcase
      end else len = $urandom_range(0, 15);
      rr_rand = (i % 2) == 1;
      burst(8'($urandom), $urandom, len, bt, !rr_rand, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
